// File: rtl/matrix_pkg.sv
// matrix_pkg: shared state encoding and default index width for the matrix read path
package matrix_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam int IDX_W = 8;
endpackage

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: two-level wrap counter (inner 0..NI-1, outer 0..NO-1)
// Ports: clk, rst (async active-low), advance, clear -> inner, outer, isLast
module matrix_index_counter #(
  parameter int W = 8,
  parameter int NI = 2,
  parameter int NO = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] inner,
  output logic [W-1:0] outer,
  output logic         isLast
);
  logic iend;
  assign iend = inner == W'(NI - 1);
  assign isLast = iend && outer == W'(NO - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inner <= '0;
      outer <= '0;
    end else if (clear) begin
      inner <= '0;
      outer <= '0;
    end else if (advance) begin
      inner <= iend ? '0 : inner + 1'b1;
      outer <= iend ? outer + 1'b1 : outer;
    end
endmodule

// File: rtl/matrix_reader.sv
// matrix_reader: streams an MxN matrix store out as a valid/ready element stream
// Ports: clk, rst (async active-low), start; rowSel/colSel drive the store,
//   memData is its combinational read; outData/outValid/outReady/outLast form
//   the stream; busy is high outside IDLE; done pulses after the final beat.
// MATRIX_READER_TRANSPOSE_EN: column-major traversal (emits the transpose).
module matrix_reader
  import matrix_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 2,
  parameter int DW = IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [DW-1:0] rowSel,
  output logic [DW-1:0] colSel,
  input  logic [DW-1:0] memData,
  output logic [DW-1:0] outData,
  output logic          outValid,
  input  logic          outReady,
  output logic          outLast,
  output logic          busy,
  output logic          done
);
  logic [1:0] st;
  logic isLast, load, hs, fin;
  assign hs = outValid && outReady;
  // IDLE+start captures (0,0); in STREAM capture whenever the output slot frees up
  assign load = st == IDLE ? start : st == STREAM && (!outValid || outReady);
  assign fin = st == DRAIN && hs;
  assign busy = st != IDLE;
`ifdef MATRIX_READER_TRANSPOSE_EN
  matrix_index_counter #(.W(DW), .NI(M), .NO(N)) u_idx (
    .clk, .rst, .advance(load && !isLast), .clear(fin),
    .inner(rowSel), .outer(colSel), .isLast
  );
`else
  matrix_index_counter #(.W(DW), .NI(N), .NO(M)) u_idx (
    .clk, .rst, .advance(load && !isLast), .clear(fin),
    .inner(colSel), .outer(rowSel), .isLast
  );
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      outData <= '0;
      outValid <= 1'b0;
      outLast <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st == IDLE ? (start ? (isLast ? DRAIN : STREAM) : IDLE) :
            st == STREAM ? (load && isLast ? DRAIN : STREAM) :
            st == DRAIN ? (hs ? IDLE : DRAIN) : IDLE;
      if (load) begin
        outData <= memData;
        outLast <= isLast;
      end else if (hs) outLast <= 1'b0;
      outValid <= load || (outValid && !outReady);
      done <= fin;
    end
endmodule
